seq_normalizer: RTL

- Multi-cycle normalizer: the inverse of the barrel shifter.
- The barrel shifter applies a given shift. This block finds the shift amount that moves the first set bit to the MSB (leading-zero count) or to the LSB (trailing-zero count). It returns that count and the normalized value.
- It resolves one shift-amount bit per cycle, by binary search, over SHIFT_WIDTH cycles.
- Used by FP/ALU datapaths ahead of the barrel shifter. Valid/ready on both sides.

---
 rtl/seq_normalizer.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: binary-searches the leading (or trailing) zero count, one shift bit per cycle.
// Optional macro SEQ_NORMALIZER_ZERO_BYPASS_EN: zero operands complete one edge after accept.
module seq_normalizer #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned SHIFT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in,
  input  logic                   left_right,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic [SHIFT_WIDTH-1:0] shift,
  output logic                   zero
);

  localparam int unsigned KW = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       work;
  logic [SHIFT_WIDTH-1:0] count;
  logic [KW-1:0]          k;
  logic                   lr_q;
  logic                   op_zero;

  logic [SHIFT_WIDTH-1:0] step;
  logic [WIDTH-1:0]       hi_mask;
  logic                   top_zero;
  logic [WIDTH-1:0]       work_nxt;
  logic [SHIFT_WIDTH-1:0] count_nxt;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // One binary-search stage: test the top 2**k bits and shift them out if empty.
  always_comb begin
    step         = SHIFT_WIDTH'(1) << k;
    hi_mask      = ~({WIDTH{1'b1}} >> step);
    top_zero     = (work & hi_mask) == '0;
    work_nxt     = top_zero ? (work << step) : work;
    count_nxt    = count;
    count_nxt[k] = top_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      work      <= '0;
      count     <= '0;
      k         <= '0;
      lr_q      <= 1'b0;
      op_zero   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      shift     <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work     <= left_right ? bit_rev(in) : in;
            lr_q     <= left_right;
            op_zero  <= (in == '0);
            count    <= '0;
            k        <= KW'(SHIFT_WIDTH - 1);
            in_ready <= 1'b0;
            state    <= S_RUN;
`ifdef SEQ_NORMALIZER_ZERO_BYPASS_EN
            // Zero operand: preload the all-ones count and run only the final stage.
            if (in == '0) begin
              count <= '1;
              k     <= '0;
            end
`endif
          end
        end
        S_RUN: begin
          work  <= work_nxt;
          count <= count_nxt;
          if (k == '0) begin
            out       <= lr_q ? bit_rev(work_nxt) : work_nxt;
            shift     <= count_nxt;
            zero      <= op_zero;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            k <= k - KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
